dm_sb_sequencer: RTL and testbench
==================================

Name: dm_sb_sequencer

Overview:
- Sequences System Bus Access (SBA) transactions for the debug module.
- Turns DMI-side writes and reads of sbaddress0/sbdata0 into single bus transactions on a req/gnt/r_valid master port, using the sbcs control fields (sbaccess, sbautoincrement, sbreadonaddr, sbreadondata).
- Owns the bus address register, the SBA state machine, byte-lane steering, and error classification.
- Sits between dm_csrs (register file) and the SoC interconnect master port.

Parameters:
- BusWidth, 32, bus data/address width; only 32 is supported (sbaccess up to 32-bit).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmactive_i  in  1  dmcontrol.dmactive; low blocks new transactions
- sbaddress_we_i  in  1  DMI write to sbaddress0
- sbaddress_wdata_i  in  32  value written to sbaddress0
- sbaddress_o  out  32  current address register
- sbdata_we_i  in  1  DMI write to sbdata0 (starts bus write)
- sbdata_wdata_i  in  32  value written to sbdata0
- sbdata_re_i  in  1  DMI read of sbdata0 (readondata trigger)
- sbaccess_i  in  3  sbcs.sbaccess (0=8, 1=16, 2=32 bit)
- sbautoincrement_i  in  1  sbcs.sbautoincrement
- sbreadonaddr_i  in  1  sbcs.sbreadonaddr
- sbreadondata_i  in  1  sbcs.sbreadondata
- sbbusy_o  out  1  transaction in progress
- sbbusyerror_o  out  1  one-cycle pulse: trigger arrived while busy
- sberror_valid_o  out  1  one-cycle pulse: sberror_o is valid
- sberror_o  out  3  error code (cmderr-style encoding, see Behaviour)
- sbdata_rvalid_o  out  1  one-cycle pulse: read data valid
- sbdata_rdata_o  out  32  read data, right-aligned to bit 0
- master_req_o  out  1  bus request
- master_add_o  out  32  bus address (word-aligned)
- master_we_o  out  1  1=write
- master_wdata_o  out  32  write data, lane-replicated
- master_be_o  out  4  byte enables
- master_gnt_i  in  1  request accepted
- master_r_valid_i  in  1  response valid
- master_r_err_i  in  1  bus error on response
- master_r_rdata_i  in  32  response data

Behaviour:
- Reset values:
  - state=Idle; address=0.
  - All pulses, master_req_o, master_we_o, master_be_o and master_wdata_o = 0.
  - sbdata_rdata_o=0; sberror_o=0.
- States:
  - Idle: no transaction in flight.
  - Read: master_req_o=1, master_we_o=0.
  - Write: master_req_o=1, master_we_o=1.
  - WaitRead: request granted, waiting for the read response.
  - WaitWrite: request granted, waiting for the write response.
- Triggers, evaluated only in Idle with dmactive_i=1:
  - sbdata_we_i -> Write.
  - sbaddress_we_i with sbreadonaddr_i -> Read; the new address is used.
  - sbdata_re_i with sbreadondata_i -> Read.
- Simultaneous triggers:
  - sbaddress_we_i is loaded first, then evaluated.
  - If a data write and a read trigger coincide, the write wins.
- Triggers outside Idle:
  - sbaddress_we_i/sbdata_we_i are ignored (no register update) and pulse sbbusyerror_o.
  - sbdata_re_i with readondata pulses sbbusyerror_o.
- Pre-checks in Idle, completed in the same cycle (no bus request):
  - sbaccess_i>2 -> sberror_o=4 (size).
  - Address misaligned to the access size -> sberror_o=3 (alignment).
  - Either case: sberror_valid_o pulses and state stays Idle.
- Latency and handshake:
  - Trigger cycle T -> master_req_o=1 from T+1.
  - master_req_o and address/we/be/wdata are held stable until master_gnt_i.
  - Grant cycle -> WaitRead/WaitWrite, master_req_o=0 next cycle.
  - Response may arrive at the earliest one cycle after grant.
- sbbusy_o = (state != Idle), registered.
  - Asserts at T+1.
  - Deasserts in the cycle after master_r_valid_i.
- Address and lane steering:
  - master_add_o = {address[31:2], 2'b00}.
  - master_be_o: 8-bit = 1<<a[1:0]; 16-bit = 2'b11<<a[1:0]; 32-bit = 4'hF.
  - master_wdata_o replicates the sized data into all lanes.
  - Read data is shifted right by 8*a[1:0], then masked to the access size.
- Completion (response cycle R), effective at R+1:
  - Read: sbdata_rvalid_o pulses with sbdata_rdata_o.
  - Write: no data pulse.
  - master_r_err_i=1: sberror_o=2 (bad address) with sberror_valid_o, no rvalid pulse, no autoincrement.
  - Success with sbautoincrement_i: address += (1<<sbaccess); the 32-bit wrap 0xFFFFFFFC+4 -> 0 is legal.
- dmactive_i low:
  - In Idle: blocks triggers.
  - Mid-transaction: the in-flight request/response completes normally (no aborted req), then the block returns to Idle.
  - The address register is held.
- rst_ni assertion mid-transaction: immediate return to reset values; the interconnect is reset on the same domain.

Decomposition:
- Add to package dm:
  - sba_state_e (Idle, Read, Write, WaitRead, WaitWrite).
  - sberror codes SbErrNone=0, SbErrTimeout=1, SbErrBadAddr=2, SbErrAlign=3, SbErrSize=4, SbErrOther=7.
  - Access-size encodings SbAccess8/16/32.
- One sub-module: dm_sb_lane (combinational be/wdata replication and rdata extraction), reused by a future 64-bit variant.

Test Plan:
- 32-bit write: addr=0x1000, sbdata write 0xDEADBEEF, gnt at T+3 -> req T+1..T+3, be=4'hF, wdata=0xDEADBEEF, sbbusy clears after r_valid, no error.
- 8-bit readonaddr: addr write 0x2003 with rdata=0xAABBCCDD -> be=4'b1000, add=0x2000, sbdata_rdata_o=0x000000AA.
- Autoincrement 16-bit readondata: addr=0x3000, three sbdata reads -> bus addresses 0x3000, 0x3002, 0x3004; final sbaddress_o=0x3006.
- Errors:
  - 16-bit access at 0x4001 -> sberror=3, no req.
  - sbaccess=3 -> sberror=4.
  - r_err=1 -> sberror=2, address not incremented.
- Busy violations: sbdata write during WaitWrite -> sbbusyerror pulse, wdata unchanged. dmactive low during Read -> transaction completes, then no new trigger accepted.
- Wrap: addr=0xFFFFFFFC, 32-bit autoincrement write -> sbaddress_o=0x00000000.

Source files
------------

// File: rtl/dm_sb_sequencer_pkg.sv
// Shared types and constants for the system bus access sequencer.
//   sba_state_e  : SBA state machine encoding
//   SbErr*       : sberror codes (cmderr-style)
//   SbAccess*    : sbcs.sbaccess size encodings
//   sb_misaligned: address alignment check for a given access size
package dm_sb_sequencer_pkg;

  typedef enum logic [2:0] {
    SbaIdle      = 3'd0,
    SbaRead      = 3'd1,
    SbaWrite     = 3'd2,
    SbaWaitRead  = 3'd3,
    SbaWaitWrite = 3'd4
  } sba_state_e;

  localparam logic [2:0] SbErrNone    = 3'd0;
  localparam logic [2:0] SbErrTimeout = 3'd1;
  localparam logic [2:0] SbErrBadAddr = 3'd2;
  localparam logic [2:0] SbErrAlign   = 3'd3;
  localparam logic [2:0] SbErrSize    = 3'd4;
  localparam logic [2:0] SbErrOther   = 3'd7;

  localparam logic [2:0] SbAccess8  = 3'd0;
  localparam logic [2:0] SbAccess16 = 3'd1;
  localparam logic [2:0] SbAccess32 = 3'd2;

  function automatic logic sb_misaligned(input logic [2:0] access, input logic [1:0] offset);
    logic result;
    result = 1'b0;
    case (access)
      SbAccess16: result = offset[0];
      SbAccess32: result = |offset;
      default:    result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dm_sb_sequencer_if.sv
// Bus master port of the SBA sequencer (req/gnt/r_valid protocol).
//   req, add, we, wdata, be : request phase, driven by the master
//   gnt                     : request accepted, driven by the interconnect
//   r_valid, r_err, r_rdata : response phase, driven by the interconnect
interface dm_sb_sequencer_if #(
  parameter int BusWidth = 32
);
  logic                    req;
  logic [BusWidth-1:0]     add;
  logic                    we;
  logic [BusWidth-1:0]     wdata;
  logic [BusWidth/8-1:0]   be;
  logic                    gnt;
  logic                    r_valid;
  logic                    r_err;
  logic [BusWidth-1:0]     r_rdata;

  modport master (
    output req, add, we, wdata, be,
    input  gnt, r_valid, r_err, r_rdata
  );

  modport slave (
    input  req, add, we, wdata, be,
    output gnt, r_valid, r_err, r_rdata
  );
endinterface

// File: rtl/dm_sb_lane.sv
// Byte-lane steering for a 32-bit system bus.
//   access  : sbaccess size code (8/16/32 bit)
//   offset  : address bits [1:0]
//   wdata   : right-aligned write data from sbdata0
//   r_rdata : raw bus read data
//   be      : byte enables for the addressed lanes
//   wdata_rep : sized write data replicated into every lane
//   rdata   : read data shifted down to bit 0 and masked to the access size
module dm_sb_lane
  import dm_sb_sequencer_pkg::*;
(
  input  logic [2:0]  access,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] r_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = r_rdata >> {offset, 3'b000};
    be        = 4'hF;
    wdata_rep = wdata;
    rdata     = shifted;
    case (access)
      SbAccess8: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {24'h0, shifted[7:0]};
      end
      SbAccess16: begin
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {16'h0, shifted[15:0]};
      end
      default: begin
        be        = 4'hF;
        wdata_rep = wdata;
        rdata     = shifted;
      end
    endcase
  end

endmodule

// File: rtl/dm_sb_sequencer.sv
// System Bus Access sequencer: turns DMI accesses of sbaddress0/sbdata0 into
// single transactions on the bus master port.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   dmactive_i             : low blocks new transactions
//   sbaddress_* / sbdata_* : DMI-side register writes/reads and sbcs fields
//   sbbusy_o, sbbusyerror_o, sberror_*, sbdata_rvalid_o/rdata_o : status back to dm_csrs
//   bus                    : req/gnt/r_valid master port
//
// state        | meaning
// -------------+--------------------------------------------------
// SbaIdle      | no transaction in flight, triggers evaluated
// SbaRead      | read request driven, waiting for gnt
// SbaWrite     | write request driven, waiting for gnt
// SbaWaitRead  | read granted, waiting for r_valid
// SbaWaitWrite | write granted, waiting for r_valid
module dm_sb_sequencer
  import dm_sb_sequencer_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dmactive_i,
  input  logic                sbaddress_we_i,
  input  logic [BusWidth-1:0] sbaddress_wdata_i,
  output logic [BusWidth-1:0] sbaddress_o,
  input  logic                sbdata_we_i,
  input  logic [BusWidth-1:0] sbdata_wdata_i,
  input  logic                sbdata_re_i,
  input  logic [2:0]          sbaccess_i,
  input  logic                sbautoincrement_i,
  input  logic                sbreadonaddr_i,
  input  logic                sbreadondata_i,
  output logic                sbbusy_o,
  output logic                sbbusyerror_o,
  output logic                sberror_valid_o,
  output logic [2:0]          sberror_o,
  output logic                sbdata_rvalid_o,
  output logic [BusWidth-1:0] sbdata_rdata_o,
  dm_sb_sequencer_if.master   bus
);

  sba_state_e  state_q, state_d;
  logic [31:0] address_q;
  logic [2:0]  access_q;
  logic [1:0]  offset_q;
  logic [31:0] wdata_q;
  logic        autoinc_q;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic [2:0]  err_q;
  logic        err_valid_q;
  logic        busyerr_q;

  logic        idle;
  logic        can_trig;
  logic        wr_trig;
  logic        rd_trig;
  logic        any_trig;
  logic        size_err;
  logic        align_err;
  logic        start_ok;
  logic        busy_viol;
  logic        done;
  logic [31:0] eff_addr;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  // An address write in the trigger cycle is loaded first, so the checks and
  // the transaction itself must see the new value.
  assign eff_addr  = sbaddress_we_i ? sbaddress_wdata_i : address_q;
  assign idle      = (state_q == SbaIdle);
  assign can_trig  = idle && dmactive_i;
  assign wr_trig   = can_trig && sbdata_we_i;
  assign rd_trig   = can_trig && !sbdata_we_i &&
                     ((sbaddress_we_i && sbreadonaddr_i) || (sbdata_re_i && sbreadondata_i));
  assign any_trig  = wr_trig || rd_trig;
  assign size_err  = (sbaccess_i > SbAccess32);
  assign align_err = !size_err && sb_misaligned(sbaccess_i, eff_addr[1:0]);
  assign start_ok  = any_trig && !size_err && !align_err;
  assign busy_viol = !idle && (sbaddress_we_i || sbdata_we_i || (sbdata_re_i && sbreadondata_i));
  assign done      = ((state_q == SbaWaitRead) || (state_q == SbaWaitWrite)) && bus.r_valid;

  dm_sb_lane u_lane (
    .access    (access_q),
    .offset    (offset_q),
    .wdata     (wdata_q),
    .r_rdata   (bus.r_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata     (lane_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SbaIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    case (state_q)
      SbaIdle: begin
        if (start_ok) state_d = wr_trig ? SbaWrite : SbaRead;
      end
      SbaRead: begin
        bus.req = 1'b1;
        if (bus.gnt) state_d = SbaWaitRead;
      end
      SbaWrite: begin
        bus.req = 1'b1;
        bus.we  = 1'b1;
        if (bus.gnt) state_d = SbaWaitWrite;
      end
      SbaWaitRead, SbaWaitWrite: begin
        if (bus.r_valid) state_d = SbaIdle;
      end
      default: state_d = SbaIdle;
    endcase
    // Lanes are only meaningful while requesting; keep them quiet otherwise.
    bus.be    = bus.req ? lane_be : 4'h0;
    bus.wdata = bus.req ? lane_wdata : 32'h0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      address_q   <= 32'h0;
      access_q    <= SbAccess8;
      offset_q    <= 2'b00;
      wdata_q     <= 32'h0;
      autoinc_q   <= 1'b0;
      rdata_q     <= 32'h0;
      rvalid_q    <= 1'b0;
      err_q       <= SbErrNone;
      err_valid_q <= 1'b0;
      busyerr_q   <= 1'b0;
    end else begin
      rvalid_q    <= 1'b0;
      err_valid_q <= 1'b0;
      busyerr_q   <= busy_viol;
      if (can_trig && sbaddress_we_i) address_q <= sbaddress_wdata_i;
      if (any_trig) begin
        if (size_err) begin
          err_q       <= SbErrSize;
          err_valid_q <= 1'b1;
        end else if (align_err) begin
          err_q       <= SbErrAlign;
          err_valid_q <= 1'b1;
        end else begin
          access_q  <= sbaccess_i;
          offset_q  <= eff_addr[1:0];
          autoinc_q <= sbautoincrement_i;
          if (wr_trig) wdata_q <= sbdata_wdata_i;
        end
      end
      if (done) begin
        if (bus.r_err) begin
          err_q       <= SbErrBadAddr;
          err_valid_q <= 1'b1;
        end else begin
          if (state_q == SbaWaitRead) begin
            rvalid_q <= 1'b1;
            rdata_q  <= lane_rdata;
          end
          // Wrap past 0xFFFFFFFC is intentional and legal.
          if (autoinc_q) address_q <= address_q + (32'd1 << access_q);
        end
      end
    end
  end

  assign bus.add         = {address_q[31:2], 2'b00};
  assign sbaddress_o     = address_q;
  assign sbbusy_o        = !idle;
  assign sbbusyerror_o   = busyerr_q;
  assign sberror_valid_o = err_valid_q;
  assign sberror_o       = err_q;
  assign sbdata_rvalid_o = rvalid_q;
  assign sbdata_rdata_o  = rdata_q;

endmodule

// File: tb/tb_dm_sb_sequencer.sv
module tb_dm_sb_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dmactive_i;
  logic        sbaddress_we_i;
  logic [31:0] sbaddress_wdata_i;
  logic [31:0] sbaddress_o;
  logic        sbdata_we_i;
  logic [31:0] sbdata_wdata_i;
  logic        sbdata_re_i;
  logic [2:0]  sbaccess_i;
  logic        sbautoincrement_i;
  logic        sbreadonaddr_i;
  logic        sbreadondata_i;
  logic        sbbusy_o;
  logic        sbbusyerror_o;
  logic        sberror_valid_o;
  logic [2:0]  sberror_o;
  logic        sbdata_rvalid_o;
  logic [31:0] sbdata_rdata_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_addr;

  dm_sb_sequencer_if bus_if ();

  dm_sb_sequencer dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .dmactive_i        (dmactive_i),
    .sbaddress_we_i    (sbaddress_we_i),
    .sbaddress_wdata_i (sbaddress_wdata_i),
    .sbaddress_o       (sbaddress_o),
    .sbdata_we_i       (sbdata_we_i),
    .sbdata_wdata_i    (sbdata_wdata_i),
    .sbdata_re_i       (sbdata_re_i),
    .sbaccess_i        (sbaccess_i),
    .sbautoincrement_i (sbautoincrement_i),
    .sbreadonaddr_i    (sbreadonaddr_i),
    .sbreadondata_i    (sbreadondata_i),
    .sbbusy_o          (sbbusy_o),
    .sbbusyerror_o     (sbbusyerror_o),
    .sberror_valid_o   (sberror_valid_o),
    .sberror_o         (sberror_o),
    .sbdata_rvalid_o   (sbdata_rvalid_o),
    .sbdata_rdata_o    (sbdata_rdata_o),
    .bus               (bus_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference lane model: byte counts and modular arithmetic.
  function automatic logic [3:0] ref_be(input int nbytes, input int off);
    int v;
    v = ((1 << nbytes) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input int nbytes, input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = d[(i % nbytes)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rdata(input int nbytes, input int off, input logic [31:0] d);
    logic [31:0] mask;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    return (d >> (8 * off)) & mask;
  endfunction

  task automatic set_addr(input logic [31:0] a);
    sbreadonaddr_i    = 1'b0;
    sbaddress_we_i    = 1'b1;
    sbaddress_wdata_i = a;
    tick();
    sbaddress_we_i    = 1'b0;
    m_addr            = a;
    check("set_addr", sbaddress_o, a);
  endtask

  // kind: 0 = sbdata write, 1 = read on address write, 2 = read on sbdata read
  // viol: 1 = busy writes during the transaction, 2 = dmactive drops mid-read
  task automatic run_txn(input int kind, input logic [31:0] new_addr, input logic [31:0] wd,
                         input logic [2:0] acc, input bit autoinc, input int gdly, input int rdly,
                         input bit rerr, input logic [31:0] rd, input int viol);
    logic [31:0] a;
    int nbytes, off;
    logic [2:0] exp_err;
    bit is_wr;
    is_wr  = (kind == 0);
    a      = (kind == 1) ? new_addr : m_addr;
    nbytes = (acc > 3'd2) ? 8 : (1 << acc);
    off    = int'(a % 4);
    exp_err = (acc > 3'd2) ? 3'd4 : ((a % nbytes) != 0) ? 3'd3 : 3'd0;
    sbaccess_i        = acc;
    sbautoincrement_i = autoinc;
    sbreadonaddr_i    = (kind == 1);
    sbreadondata_i    = (kind == 2);
    sbdata_wdata_i    = wd;
    sbaddress_wdata_i = new_addr;
    sbdata_we_i       = (kind == 0);
    sbaddress_we_i    = (kind == 1);
    sbdata_re_i       = (kind == 2);
    tick();
    sbdata_we_i = 1'b0; sbaddress_we_i = 1'b0; sbdata_re_i = 1'b0;
    if (kind == 1) m_addr = new_addr;
    if (exp_err != 3'd0) begin
      check("pre_err_valid", sberror_valid_o, 1);
      check("pre_err_code", sberror_o, exp_err);
      check("pre_no_req", bus_if.req, 0);
      check("pre_not_busy", sbbusy_o, 0);
      check("pre_addr", sbaddress_o, m_addr);
      return;
    end
    check("busy_rise", sbbusy_o, 1);
    for (int i = 0; i <= gdly; i++) begin
      if (viol == 1 && i == 1) check("busyerr_req", sbbusyerror_o, 1);
      check("req", bus_if.req, 1);
      check("we", bus_if.we, is_wr);
      check("add", bus_if.add, {a[31:2], 2'b00});
      check("be", bus_if.be, ref_be(nbytes, off));
      if (is_wr) check("wdata", bus_if.wdata, ref_wdata(nbytes, wd));
      if (viol == 1 && i == 0) begin
        sbdata_we_i = 1'b1; sbdata_wdata_i = ~wd;
        sbaddress_we_i = 1'b1; sbaddress_wdata_i = a ^ 32'h0000_0F00;
      end
      if (viol == 2 && i == 0) dmactive_i = 1'b0;
      if (i == gdly) bus_if.gnt = 1'b1;
      tick();
      sbdata_we_i = 1'b0; sbaddress_we_i = 1'b0;
      bus_if.gnt = 1'b0;
    end
    check("req_drop", bus_if.req, 0);
    check("busy_wait", sbbusy_o, 1);
    for (int j = 0; j < rdly; j++) begin
      if (viol == 1 && j == 0) begin sbdata_we_i = 1'b1; sbdata_wdata_i = 32'h1234_5678; end
      tick();
      sbdata_we_i = 1'b0;
      if (viol == 1 && j == 0) check("busyerr_wait", sbbusyerror_o, 1);
    end
    bus_if.r_valid = 1'b1; bus_if.r_err = rerr; bus_if.r_rdata = rd;
    tick();
    bus_if.r_valid = 1'b0; bus_if.r_err = 1'b0; bus_if.r_rdata = $urandom;
    if (!rerr && autoinc) m_addr = m_addr + nbytes;
    check("busy_fall", sbbusy_o, 0);
    check("rvalid", sbdata_rvalid_o, (!is_wr && !rerr));
    if (!is_wr && !rerr) check("rdata", sbdata_rdata_o, ref_rdata(nbytes, off, rd));
    check("err_valid", sberror_valid_o, rerr);
    if (rerr) check("err_badaddr", sberror_o, 2);
    check("addr_after", sbaddress_o, m_addr);
    tick();
    check("rvalid_pulse", sbdata_rvalid_o, 0);
    if (viol == 2) begin
      sbdata_re_i = 1'b1; sbaddress_we_i = 1'b1; sbaddress_wdata_i = 32'hFFFF_0000;
      tick();
      sbdata_re_i = 1'b0; sbaddress_we_i = 1'b0;
      check("inactive_busy", sbbusy_o, 0);
      check("inactive_req", bus_if.req, 0);
      check("inactive_addr", sbaddress_o, m_addr);
      tick();
      check("inactive_req2", bus_if.req, 0);
      dmactive_i = 1'b1;
    end
  endtask

  initial begin
    rst_ni = 1'b0; dmactive_i = 1'b1;
    sbaddress_we_i = 1'b0; sbaddress_wdata_i = 32'h0;
    sbdata_we_i = 1'b0; sbdata_wdata_i = 32'h0; sbdata_re_i = 1'b0;
    sbaccess_i = 3'd2; sbautoincrement_i = 1'b0;
    sbreadonaddr_i = 1'b0; sbreadondata_i = 1'b0;
    bus_if.gnt = 1'b0; bus_if.r_valid = 1'b0; bus_if.r_err = 1'b0; bus_if.r_rdata = 32'h0;
    m_addr = 32'h0;
    #12;
    check("rst_addr", sbaddress_o, 0);
    check("rst_busy", sbbusy_o, 0);
    check("rst_req", bus_if.req, 0);
    check("rst_we", bus_if.we, 0);
    check("rst_be", bus_if.be, 0);
    check("rst_wdata", bus_if.wdata, 0);
    check("rst_rdata", sbdata_rdata_o, 0);
    check("rst_err", {sberror_valid_o, sberror_o}, 0);
    check("rst_pulses", {sbdata_rvalid_o, sbbusyerror_o}, 0);
    rst_ni = 1'b1;
    tick();

    // 32-bit write with grant at T+3
    set_addr(32'h1000);
    run_txn(0, 32'h0, 32'hDEAD_BEEF, 3'd2, 1'b0, 2, 0, 1'b0, 32'h0, 0);
    // 8-bit read on address write
    run_txn(1, 32'h2003, 32'h0, 3'd0, 1'b0, 0, 0, 1'b0, 32'hAABB_CCDD, 0);
    // 16-bit autoincrement read on data read
    set_addr(32'h3000);
    for (int k = 0; k < 3; k++)
      run_txn(2, 32'h0, 32'h0, 3'd1, 1'b1, k, 1, 1'b0, $urandom, 0);
    check("autoinc_final", sbaddress_o, 32'h3006);
    // pre-check errors
    set_addr(32'h4001);
    run_txn(0, 32'h0, 32'h55AA_55AA, 3'd1, 1'b0, 0, 0, 1'b0, 32'h0, 0);
    run_txn(0, 32'h0, 32'h55AA_55AA, 3'd3, 1'b0, 0, 0, 1'b0, 32'h0, 0);
    // bus error: no increment
    set_addr(32'h5000);
    run_txn(2, 32'h0, 32'h0, 3'd2, 1'b1, 1, 1, 1'b1, 32'hFFFF_FFFF, 0);
    // busy violations during request and response wait
    run_txn(0, 32'h0, 32'hCAFE_F00D, 3'd2, 1'b0, 3, 2, 1'b0, 32'h0, 1);
    // dmactive dropped mid-read
    run_txn(2, 32'h0, 32'h0, 3'd2, 1'b0, 2, 1, 1'b0, 32'h0102_0304, 2);
    // address wrap
    set_addr(32'hFFFF_FFFC);
    run_txn(0, 32'h0, 32'h0BAD_F00D, 3'd2, 1'b1, 0, 0, 1'b0, 32'h0, 0);
    check("wrap", sbaddress_o, 32'h0);
    check("no_busyerr", sbbusyerror_o, 0);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_txn(kind, $urandom & 32'h0000_FFFF, $urandom, 3'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2),
              ($urandom_range(0, 3) == 0), $urandom, 0);
    end

    // reset mid-transaction
    set_addr(32'h6000);
    sbaccess_i = 3'd2; sbdata_wdata_i = 32'h7777_7777; sbdata_we_i = 1'b1;
    tick();
    sbdata_we_i = 1'b0;
    check("pre_rst_req", bus_if.req, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_req", bus_if.req, 0);
    check("mid_rst_busy", sbbusy_o, 0);
    check("mid_rst_addr", sbaddress_o, 0);
    check("mid_rst_lanes", {bus_if.be, bus_if.wdata}, 0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_req", bus_if.req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
